uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

Receive-side controller for the UART RX path. It sequences the 3-sample majority-vote bit sampler by generating `dat_samp_en` and the per-bit `edge_cnt`. It consumes the sampler's `sampled_bit` once per bit slot to check the start bit, deserialize data LSB-first, check parity and check the stop bit. A validated byte is presented on `P_DATA` with a one-cycle `data_valid` pulse; the block sits between the RX line and the RX-side CDC/register file.

## Interface
- `DATA_WIDTH`, default 8: number of data bits per frame.
- `CLK` input, 1 bit: oversampling clock.
- `RST` input, 1 bit: asynchronous, active-low reset.
- `RX_IN` input, 1 bit: serial line, idle high, already synchronized to `CLK`.
- `PAR_EN` input, 1 bit: 1 = frame carries a parity bit.
- `PAR_TYP` input, 1 bit: 0 = even parity, 1 = odd parity.
- `Prescale` input, 6 bits: oversampling ratio per bit; legal values are 8, 16 and 32.
- `sampled_bit` input, 1 bit: majority-voted bit from the sampler, updated on the clock where `edge_cnt == Prescale-1`.
- `dat_samp_en` output, 1 bit: sampler enable.
- `edge_cnt` output, 5 bits: tick index within the current bit slot, range 0..Prescale-1.
- `bit_cnt` output, 4 bits: index of the current bit slot within the frame; start bit = 0.
- `P_DATA` output, DATA_WIDTH bits: last valid received byte.
- `data_valid` output, 1 bit: one-cycle pulse when `P_DATA` updates.
- `par_err` output, 1 bit: parity mismatch in the last frame.
- `stp_err` output, 1 bit: stop bit sampled as 0 in the last frame.
- `strt_glitch` output, 1 bit: one-cycle pulse when the start bit sampled as 1.

## Operation
- Reset value of every output is 0. After reset the state is IDLE and the internal shift register and latched config are 0.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- `dat_samp_en` is 1 in START, DATA, PARITY and STOP, and 0 in IDLE and DONE.
- `edge_cnt` and `bit_cnt` are 0 in IDLE and DONE.

State behaviour:
- **IDLE:** `RX_IN == 0` sends the block to START on the next cycle. On the START transition:
  - latch `Prescale`, `PAR_EN` and `PAR_TYP` for the whole frame;
  - clear `par_err` and `stp_err`.
- **Counters:** `edge_cnt` increments every cycle while enabled. At latched `Prescale-1` it wraps to 0, `bit_cnt` increments, and the state advances:
  - START -> DATA;
  - DATA -> DATA until DATA_WIDTH slots are done;
  - then DATA -> PARITY if `PAR_EN`, else DATA -> STOP;
  - PARITY -> STOP;
  - STOP -> DONE.
- **Consume strobe:** an internal `chk` is registered high in the cycle after each slot wrap, together with the kind and index of the finished slot. On `chk` the block consumes `sampled_bit` for that finished slot:
  - **Start slot:** `sampled_bit == 1` pulses `strt_glitch`, forces IDLE and clears the counters, even though DATA slot 0 has already begun.
  - **Data slot:** shift right, with `sampled_bit` entering the MSB, so bit 0 arrives first.
  - **Parity slot:** expected = XOR of the data bits for even parity, XNOR for odd. A mismatch sets `par_err`.
  - **Stop slot** (consumed in DONE): `sampled_bit == 0` sets `stp_err`.
- **Frame result:** if `stp_err` and `par_err` would both be 0, `P_DATA` loads the shift register and `data_valid` pulses. Otherwise `P_DATA` holds its previous value and there is no pulse. Errors stay asserted until the next START entry.
- **DONE exit:** DONE lasts exactly one cycle. It goes to START if `RX_IN == 0`, which is a back-to-back frame and clears the errors, otherwise to IDLE.
- **Reset mid-frame:** asynchronously returns to IDLE with all outputs 0. A partial byte is never presented.
- **Config changes:** changes to `Prescale`, `PAR_EN` or `PAR_TYP` mid-frame have no effect until the next START entry.

## Timing
- Let t0 be the first cycle in START (`edge_cnt = 0`), P the latched prescale, and N = 1 + DATA_WIDTH + PAR_EN + 1.
- Slot k occupies cycles t0+k·P through t0+(k+1)·P−1.
- Slot k is consumed at cycle t0+(k+1)·P.
- The start glitch is reported at t0+P.
- DONE is at t0+N·P.
- `data_valid`, `P_DATA`, `par_err` and `stp_err` are visible at t0+N·P+1.
- `par_err` is set at t0+(N−1)·P+1.
- IDLE sees `RX_IN` low at cycle t; t0 = t+1.
- Minimum frame-to-frame spacing is N·P+1 cycles.

## Test plan
- **Plain byte:** P=8, `PAR_EN=0`, byte 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first), stop=1.
  - Required: one `data_valid` pulse at t0+81, `P_DATA=0xA5`, all errors 0, `dat_samp_en` low from t0+80.
- **Even parity, correct then wrong:** P=16, `PAR_EN=1`, `PAR_TYP=0`, byte 0x3C.
  - Parity bit 0: `data_valid` at t0+177 with `P_DATA=0x3C`.
  - Repeat with parity bit 1: `par_err=1` from t0+161, no `data_valid`, `P_DATA` stays 0x3C.
- **Framing error:** P=8, `PAR_EN=0`, byte 0x81, stop bit 0.
  - Required: `stp_err=1` at t0+81, no `data_valid`, next frame start clears `stp_err`.
- **Start glitch:** P=16, `RX_IN` low for 3 cycles then high.
  - Required: `strt_glitch` pulses for one cycle at t0+16, IDLE at t0+17, `edge_cnt`/`bit_cnt` at 0, no `data_valid`.
- **Back-to-back:** P=32, odd parity, frames 0x00 then 0xFF with the next start bit immediately after the stop bit.
  - Required: two `data_valid` pulses 353 cycles apart, `P_DATA` = 0x00 then 0xFF, no errors.
- **Reset mid-DATA:** assert `RST` low at t0+40 with P=8.
  - Required: all outputs 0 immediately; after release with the line idle, no `data_valid`.
  - A following clean frame of 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// Receive-side frame sequencer for the UART RX path. Drives the 3-sample
// majority-vote sampler (dat_samp_en, edge_cnt), consumes its voted bit once
// per bit slot, deserializes LSB-first, checks parity and stop bit, and
// presents a validated byte with a one-cycle data_valid pulse.
//
// Ports
//   CLK          oversampling clock
//   RST          asynchronous active-low reset
//   RX_IN        serial line (idle high), already synchronized to CLK
//   PAR_EN       1 = frame carries a parity bit
//   PAR_TYP      0 = even parity, 1 = odd parity
//   Prescale     oversampling ratio per bit (8, 16 or 32)
//   sampled_bit  majority-voted bit from the sampler
//   dat_samp_en  sampler enable
//   edge_cnt     tick index within the current bit slot
//   bit_cnt      slot index within the frame (start bit = 0)
//   P_DATA       last valid received byte
//   data_valid   one-cycle pulse when P_DATA updates
//   par_err      parity mismatch in the last frame
//   stp_err      stop bit sampled as 0 in the last frame
//   strt_glitch  one-cycle pulse when the start bit sampled as 1
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | line idle, waiting for a falling RX_IN
// S_START  | timing the start-bit slot
// S_DATA   | timing data slots 1..DATA_WIDTH
// S_PARITY | timing the parity slot (only when parity is enabled)
// S_STOP   | timing the stop-bit slot
// S_DONE   | one cycle: stop bit consumed, frame result published

module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  input  logic                  sampled_bit,
  output logic                  dat_samp_en,
  output logic [4:0]            edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

  state_t                  state, state_nxt, chk_kind;
  logic                    chk;
  logic                    slot_en;
  logic                    wrap;
  logic                    glitch;
  logic                    frame_go;
  logic [5:0]              p_lat;
  logic                    par_en_lat;
  logic                    par_typ_lat;
  logic [DATA_WIDTH-1:0]   shift_reg;

  // Slot-level strobes shared by the next-state logic and the datapath.
  always_comb begin
    slot_en  = state inside {S_START, S_DATA, S_PARITY, S_STOP};
    wrap     = slot_en && ({1'b0, edge_cnt} == (p_lat - 6'd1));
    // The start slot is judged one cycle after it ends, so DATA slot 0 has
    // already begun when a glitch is detected; it aborts the frame anyway.
    glitch   = chk && (chk_kind == S_START) && sampled_bit;
    frame_go = ((state == S_IDLE) || (state == S_DONE)) && !RX_IN;
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!RX_IN) state_nxt = S_START;
      S_START:  if (wrap) state_nxt = S_DATA;
      S_DATA:   if (wrap && (bit_cnt == LAST_DATA))
                  state_nxt = par_en_lat ? S_PARITY : S_STOP;
      S_PARITY: if (wrap) state_nxt = S_STOP;
      S_STOP:   if (wrap) state_nxt = S_DONE;
      S_DONE:   state_nxt = RX_IN ? S_IDLE : S_START;
      default:  state_nxt = S_IDLE;
    endcase
    if (glitch) state_nxt = S_IDLE;
  end

  // Output logic
  always_comb begin
    dat_samp_en = slot_en;
    strt_glitch = glitch;
  end

  // Slot counters; both read 0 outside the timed states.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (frame_go || glitch || !slot_en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (wrap) begin
      edge_cnt <= '0;
      bit_cnt  <= (state == S_STOP) ? 4'd0 : bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 5'd1;
    end
  end

  // Consume strobe, deserializer, frame checks and latched frame config.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      chk         <= 1'b0;
      chk_kind    <= S_IDLE;
      shift_reg   <= '0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      p_lat       <= '0;
      par_en_lat  <= 1'b0;
      par_typ_lat <= 1'b0;
    end else begin
      chk        <= wrap;
      chk_kind   <= state;
      data_valid <= 1'b0;
      if (chk) begin
        case (chk_kind)
          S_DATA:   shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
          S_PARITY: if (sampled_bit != (^shift_reg ^ par_typ_lat)) par_err <= 1'b1;
          S_STOP: begin
            if (!sampled_bit) begin
              stp_err <= 1'b1;
            end else if (!par_err) begin
              P_DATA     <= shift_reg;
              data_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      // A new frame starts with fresh config and clean error flags; this
      // also covers a back-to-back start leaving DONE.
      if (frame_go) begin
        p_lat       <= Prescale;
        par_en_lat  <= PAR_EN;
        par_typ_lat <= PAR_TYP;
        par_err     <= 1'b0;
        stp_err     <= 1'b0;
      end
    end
  end

endmodule
